// File: rtl/cache_sa_wb_pkg.sv
// Shared definitions for the set-associative write-back cache.
//   state_t    - controller states
//   REQ_READ / REQ_WRITE - req_type encodings
//   way_bits() - index width for a given associativity (at least 1 bit)
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_DONE
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_sa_wb_if.sv
// Core-request and backing-memory signals of cache_sa_wb.
//   slave  : cache view (accepts core requests, drives memory requests)
//   master : environment view (core + backing memory)
interface cache_sa_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_type;
  logic              req_do;
  logic [DATA_W-1:0] O_data;
  logic              req_done;
  logic              req_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  req_addr, req_data, req_type, req_do, mem_ack, mem_rdata,
    output O_data, req_done, req_busy, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport master (
    output req_addr, req_data, req_type, req_do, mem_ack, mem_rdata,
    input  O_data, req_done, req_busy, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_sa_wb_tag_match.sv
// Combinational tag compare across all ways of one set.
//   valid_i / tag_i      : per-way state of the selected set
//   req_tag_i            : tag of the pending request
//   hit_o / hit_way_o    : match found and which way
//   any_invalid_o / first_invalid_way_o : lowest-numbered empty way
module cache_tag_match
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int TAG_W = 24,
  parameter int WAY_W = way_bits(WAYS)
) (
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAYS-1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic                       hit_o,
  output logic [WAY_W-1:0]           hit_way_o,
  output logic [WAY_W-1:0]           first_invalid_way_o,
  output logic                       any_invalid_o
);

  // Scan from the top down so the lowest-numbered way wins.
  always_comb begin
    hit_o               = 1'b0;
    hit_way_o           = '0;
    first_invalid_way_o = '0;
    any_invalid_o       = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_i[w] && (tag_i[w] == req_tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
      if (!valid_i[w]) begin
        any_invalid_o       = 1'b1;
        first_invalid_way_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// Set-associative, write-back, write-allocate cache with single-word lines.
//   clk, reset : clock, synchronous active-high reset
//   bus        : core request port (req_*, O_data, req_done, req_busy),
//                memory port (mem_*), hit/miss counters
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for req_do; request latched on acceptance
// LOOKUP    | tag compare; hit served, miss picks a victim
// WRITEBACK | dirty victim written to memory
// REFILL    | read-miss line fetched from memory
// DONE      | req_done pulse, back to IDLE
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          reset,
  cache_sa_wb_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int WAY_W = way_bits(WAYS);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  line_t             lines_q [SETS][WAYS];
  logic [WAY_W-1:0]  ptr_q   [SETS];
  state_t            state_q, state_d;
  logic [ADDR_W-1:2] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              type_q;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]           idx;
  logic [TAG_W-1:0]           tag;
  logic [WAYS-1:0]            set_valid;
  logic [WAYS-1:0][TAG_W-1:0] set_tag;
  logic                       hit, any_invalid;
  logic [WAY_W-1:0]           hit_way, first_invalid, miss_way;
  line_t                      miss_line, victim_line;

  assign idx = addr_q[IDX_W+1:2];
  assign tag = addr_q[ADDR_W-1:IDX_W+2];

  always_comb begin
    set_valid = '0;
    set_tag   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = lines_q[idx][w].valid;
      set_tag[w]   = lines_q[idx][w].tag;
    end
  end

  cache_tag_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_match (
    .valid_i             (set_valid),
    .tag_i               (set_tag),
    .req_tag_i           (tag),
    .hit_o               (hit),
    .hit_way_o           (hit_way),
    .first_invalid_way_o (first_invalid),
    .any_invalid_o       (any_invalid)
  );

  assign miss_way    = any_invalid ? first_invalid : ptr_q[idx];
  assign miss_line   = lines_q[idx][miss_way];
  assign victim_line = lines_q[idx][victim_q];

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      ST_IDLE:   if (bus.req_do) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit) begin
          state_d = ST_DONE;
        end else begin
          victim_d = miss_way;
          if (miss_line.valid && miss_line.dirty) state_d = ST_WRITEBACK;
          else if (type_q == REQ_READ)            state_d = ST_REFILL;
          else                                    state_d = ST_DONE;
        end
      end
      ST_WRITEBACK: if (bus.mem_ack) state_d = (type_q == REQ_READ) ? ST_REFILL : ST_DONE;
      ST_REFILL:    if (bus.mem_ack) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      victim_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= REQ_READ;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          lines_q[s][w].valid <= 1'b0;
          lines_q[s][w].dirty <= 1'b0;
        end
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (state_q == ST_IDLE && bus.req_do) begin
        addr_q  <= bus.req_addr[ADDR_W-1:2];
        wdata_q <= bus.req_data;
        type_q  <= bus.req_type;
      end
      case (state_q)
        ST_LOOKUP: begin
          if (hit) begin
            if (type_q == REQ_READ) begin
              rdata_q <= lines_q[idx][hit_way].data;
            end else begin
              lines_q[idx][hit_way].data  <= wdata_q;
              lines_q[idx][hit_way].dirty <= 1'b1;
            end
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (WAYS > 1) ptr_q[idx] <= ptr_q[idx] + WAY_W'(1);
            // Single-word lines: a write miss with no dirty victim installs directly.
            if (!(miss_line.valid && miss_line.dirty) && type_q == REQ_WRITE)
              lines_q[idx][miss_way] <= '{valid: 1'b1, dirty: 1'b1, tag: tag, data: wdata_q};
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_ack) begin
            if (type_q == REQ_READ) lines_q[idx][victim_q].dirty <= 1'b0;
            else lines_q[idx][victim_q] <= '{valid: 1'b1, dirty: 1'b1, tag: tag, data: wdata_q};
          end
        end
        ST_REFILL: begin
          if (bus.mem_ack) begin
            lines_q[idx][victim_q] <= '{valid: 1'b1, dirty: 1'b0, tag: tag, data: bus.mem_rdata};
            rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.O_data    = rdata_q;
  assign bus.req_done  = (state_q == ST_DONE);
  assign bus.req_busy  = (state_q != ST_IDLE);
  assign bus.mem_req   = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
  assign bus.mem_we    = (state_q == ST_WRITEBACK);
  assign bus.mem_addr  = (state_q == ST_WRITEBACK) ? {victim_line.tag, idx, 2'b00} :
                         (state_q == ST_REFILL)    ? {addr_q, 2'b00} : '0;
  assign bus.mem_wdata = (state_q == ST_WRITEBACK) ? victim_line.data : '0;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule
